datapath_sequencer: RTL
=======================

// Module: datapath_sequencer
// PURPOSE
//  Per-thread program sequencer sitting in front of one DatapathRouter port. Fetches a block of
//  instructions from a synchronous program ROM, issues them one at a time over the router's
//  start/finished handshake, and writes each result into a result buffer. A host pulses run with
//  base/length; done pulses when the whole block has executed.
// PARAMETERS
//  INSTR_W     32   instruction width (matches INSTRUCTION_WIDTH in constants.h)
//  RES_W       32   result width (matches RESULT_WIDTH in constants.h)
//  ADDR_W      10   program ROM address width
//  RADDR_W     8    result buffer address width; also width of length and count
//  TIMEOUT     1024 watchdog limit in cycles (used only with SEQ_TIMEOUT_EN)
// PORTS
//  clock        in   1        rising-edge clock
//  resetn       in   1        asynchronous active-low reset
//  run          in   1        start pulse; sampled only in IDLE
//  base_addr    in   ADDR_W   first ROM address of block (latched on run)
//  length       in   RADDR_W  number of instructions; 0 = empty block
//  busy         out  1        high in every state except IDLE
//  done         out  1        1-cycle pulse at end of block
//  error        out  1        sticky timeout flag; cleared on next accepted run
//  rom_addr     out  ADDR_W   ROM read address
//  rom_data     in   INSTR_W  ROM data, valid 1 cycle after rom_addr
//  instruction  out  INSTR_W  to router port instruction slice
//  start        out  1        to router port start bit; 1-cycle pulse
//  result       in   RES_W    from router port result slice
//  finished     in   1        from router port finished bit (level; high = idle/result ready)
//  res_we       out  1        result buffer write strobe, 1 cycle
//  res_addr     out  RADDR_W  result index (0..length-1)
//  res_data     out  RES_W    result value
// BEHAVIOUR
//  Reset (async, all regs): state=IDLE, busy=0, done=0, error=0, start=0, res_we=0,
//   rom_addr=0, instruction=0, res_addr=0, res_data=0, count=0.
//  States: IDLE, FETCH, ISSUE, WAIT_ACK, WAIT_RES, WRITE, DONE.
//  IDLE: run=1 -> latch base/length, clear error; length=0 -> DONE, else rom_addr=base -> FETCH.
//  FETCH: 1 cycle for ROM latency -> ISSUE.
//  ISSUE: only if finished=1: instruction<=rom_data, start=1 for exactly 1 cycle -> WAIT_ACK;
//   if finished=0 (port still busy) stall in ISSUE, start stays 0.
//  WAIT_ACK: wait for finished=0 (router has accepted); finished never sampled as result here.
//  WAIT_RES: finished=1 -> res_data<=result, res_addr<=count -> WRITE.
//  WRITE: res_we=1 for 1 cycle; count+1; count==length -> DONE, else rom_addr+1 -> FETCH.
//   rom_addr wraps modulo 2^ADDR_W; no error.
//  DONE: done=1 for 1 cycle -> IDLE. busy falls in same cycle done is high? No: busy=0 only in IDLE,
//   so busy is high during the done cycle and low the cycle after.
//  Minimum per-instruction cost: FETCH+ISSUE+WAIT_ACK+WAIT_RES+WRITE = 5 cycles + datapath latency.
//  run while busy: ignored. instruction holds last issued value between issues.
//  resetn low mid-operation: immediate return to reset values; in-flight router op is abandoned.
// CONFIGURATION
//  SEQ_TIMEOUT_EN defined: cycle counter cleared on entering WAIT_ACK; counts in WAIT_ACK and
//   WAIT_RES; reaching TIMEOUT -> error=1, skip remaining instructions, go to DONE (done pulses).
//   Counter width = clog2(TIMEOUT+1).
//  SEQ_TIMEOUT_EN undefined: no counter, error tied 0, WAIT_ACK/WAIT_RES wait indefinitely.
// TESTING
//  1 Reset: resetn=0 mid-WAIT_RES -> all outputs 0, state IDLE; run next cycle restarts cleanly.
//  2 base=0x010, length=3, ROM[0x10..0x12]=A,B,C, router model returns instr+1 after 4 cycles
//    -> three start pulses carrying A,B,C; res writes idx0..2 = A+1,B+1,C+1; one done pulse.
//  3 length=0 -> done one cycle after IDLE accepts run; zero start, zero res_we.
//  4 finished held 0 by other activity for 7 cycles at ISSUE -> start delayed, asserts 1 cycle
//    after finished rises; run pulsed while busy -> ignored, no restart.
//  5 base=0x3FF, length=2 -> rom_addr 0x3FF then 0x000; results idx0,1 correct.
//  6 SEQ_TIMEOUT_EN, TIMEOUT=16, length=4, router never returns finished on 2nd instr
//    -> error=1 and done after 16 cycles of waiting; res_we count=1; next run clears error.

Source files
------------

// File: rtl/datapath_sequencer_if.sv
// datapath_sequencer_if
//   Router port bundle between the program sequencer and one DatapathRouter port.
//   master : sequencer side (drives instruction/start, receives result/finished)
//   slave  : router side
// Signals
//   instruction  INSTR_W  instruction slice presented to the router
//   start        1        one-cycle issue pulse
//   result       RES_W    result slice returned by the router
//   finished     1        level; high = router idle / result ready
interface datapath_sequencer_if #(
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned RES_W   = 32
);
    logic [INSTR_W-1:0] instruction;
    logic               start;
    logic [RES_W-1:0]   result;
    logic               finished;

    modport master (output instruction, output start, input result, input finished);
    modport slave  (input instruction, input start, output result, output finished);
endinterface

// File: rtl/datapath_sequencer.sv
// datapath_sequencer
//   Per-thread program sequencer in front of one DatapathRouter port. On a run
//   pulse it fetches length instructions from a synchronous program ROM starting
//   at base_addr, issues each over the router start/finished handshake and writes
//   each result into a result buffer at index 0..length-1. done pulses once per block.
// Optional build macro
//   SEQ_TIMEOUT_EN : adds a watchdog over WAIT_ACK/WAIT_RES; on expiry error is set
//                    (sticky until the next accepted run) and the block is abandoned.
// Ports
//   clock, resetn            rising-edge clock, asynchronous active-low reset
//   run, base_addr, length   block request (sampled only when idle)
//   busy, done, error        status
//   rom_addr, rom_data       program ROM read port (1-cycle latency)
//   rtr                      router port (master modport)
//   res_we, res_addr, res_data  result buffer write port
module datapath_sequencer #(
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned RES_W   = 32,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned RADDR_W = 8,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                run,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [RADDR_W-1:0]  length,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [INSTR_W-1:0]  rom_data,
    datapath_sequencer_if.master rtr,
    output logic                res_we,
    output logic [RADDR_W-1:0]  res_addr,
    output logic [RES_W-1:0]    res_data
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        WAIT_ACK,
        WAIT_RES,
        WRITE,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [RADDR_W-1:0]   len_q;
    logic [RADDR_W-1:0]   count_q;
    logic [RADDR_W-1:0]   count_nx;
    logic [ADDR_W-1:0]    rom_addr_q;
    logic [INSTR_W-1:0]   instr_q;
    logic                 start_q;
    logic [RADDR_W-1:0]   res_addr_q;
    logic [RES_W-1:0]     res_data_q;
    logic                 tmo_hit;

    assign count_nx = count_q + RADDR_W'(1);

`ifdef SEQ_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_q;
    logic             error_q;

    // tmo_q is the index of the current waiting cycle, so expiry lands after
    // exactly TIMEOUT cycles spent in WAIT_ACK/WAIT_RES.
    assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            tmo_q   <= '0;
            error_q <= 1'b0;
        end else begin
            if (state_q == ISSUE && rtr.finished) begin
                tmo_q <= '0;
            end else if (state_q == WAIT_ACK || state_q == WAIT_RES) begin
                tmo_q <= tmo_q + TMO_W'(1);
            end

            if (state_q == IDLE && run) begin
                error_q <= 1'b0;
            end else if ((state_q == WAIT_ACK || state_q == WAIT_RES) && state_d == DONE) begin
                error_q <= 1'b1;
            end
        end
    end

    assign error = error_q;
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT;
    assign tmo_hit        = 1'b0;
    assign error          = 1'b0;
`endif

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a real handshake step takes priority over watchdog expiry
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = (length == '0) ? DONE : FETCH;
                end
            end
            FETCH:    state_d = ISSUE;
            ISSUE: begin
                if (rtr.finished) begin
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (!rtr.finished) begin
                    state_d = WAIT_RES;
                end else if (tmo_hit) begin
                    state_d = DONE;
                end
            end
            WAIT_RES: begin
                if (rtr.finished) begin
                    state_d = WRITE;
                end else if (tmo_hit) begin
                    state_d = DONE;
                end
            end
            WRITE:    state_d = (count_nx == len_q) ? DONE : FETCH;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            len_q      <= '0;
            count_q    <= '0;
            rom_addr_q <= '0;
            instr_q    <= '0;
            start_q    <= 1'b0;
            res_addr_q <= '0;
            res_data_q <= '0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (run) begin
                        len_q   <= length;
                        count_q <= '0;
                        if (length != '0) begin
                            rom_addr_q <= base_addr;
                        end
                    end
                end
                ISSUE: begin
                    // start is registered together with the instruction so the
                    // router sees both in the same cycle (first WAIT_ACK cycle)
                    if (rtr.finished) begin
                        instr_q <= rom_data;
                        start_q <= 1'b1;
                    end
                end
                WAIT_RES: begin
                    if (rtr.finished) begin
                        res_data_q <= rtr.result;
                        res_addr_q <= count_q;
                    end
                end
                WRITE: begin
                    count_q <= count_nx;
                    if (count_nx != len_q) begin
                        rom_addr_q <= rom_addr_q + ADDR_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy            = (state_q != IDLE);
    assign done            = (state_q == DONE);
    assign res_we          = (state_q == WRITE);
    assign rom_addr        = rom_addr_q;
    assign res_addr        = res_addr_q;
    assign res_data        = res_data_q;
    assign rtr.instruction = instr_q;
    assign rtr.start       = start_q;

endmodule
